m2_block_writer: RTL



---
 rtl/m2_pkg.sv | 43 ++++
 rtl/clip_u8.sv | 23 ++
 rtl/m2_block_writer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/m2_pkg.sv
// ============================================================================
// m2_pkg : shared Milestone 2 types, SRAM plane map and block-count limits
// Revision: 1.0
// ============================================================================
`default_nettype none

package m2_pkg;

  typedef enum logic [1:0] {
    PLANE_Y = 2'd0,
    PLANE_U = 2'd1,
    PLANE_V = 2'd2
  } plane_e;

  localparam logic [17:0] C_Y_BASE   = 18'd0;
  localparam logic [17:0] C_U_BASE   = 18'd38400;
  localparam logic [17:0] C_V_BASE   = 18'd57600;
  localparam logic [17:0] C_Y_STRIDE = 18'd160;

  localparam logic [5:0] C_Y_BLOCK_COLS  = 6'd40;
  localparam logic [5:0] C_UV_BLOCK_COLS = 6'd20;
  localparam logic [4:0] C_BLOCK_ROWS    = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEAD_IN = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } bw_state_e;

  // Small constant-by-variable product built from shifted partial sums.
  function automatic logic [17:0] shift_add_mul(input logic [17:0] a, input logic [5:0] b);
    logic [17:0] acc;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clip_u8.sv
// ============================================================================
// clip_u8 : saturate a signed 32-bit sample to an unsigned 8-bit pixel
// Revision: 1.0
// ============================================================================
`default_nettype none

module clip_u8 (
  input  logic [31:0] i_sample,
  output logic [7:0]  o_pixel
);

  always_comb begin
    if (i_sample[31])
      o_pixel = 8'h00;
    else if (|i_sample[30:8])
      o_pixel = 8'hFF;
    else
      o_pixel = i_sample[7:0];
  end

endmodule

`default_nettype wire

// File: rtl/m2_block_writer.sv
// ============================================================================
// m2_block_writer : clip, pack and write one 8x8 IDCT result block to SRAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module m2_block_writer
  import m2_pkg::*;
#(
  parameter logic [17:0] Y_BASE   = C_Y_BASE,
  parameter logic [17:0] U_BASE   = C_U_BASE,
  parameter logic [17:0] V_BASE   = C_V_BASE,
  parameter logic [17:0] Y_STRIDE = C_Y_STRIDE
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Plane,
  input  logic [4:0]  Block_row,
  input  logic [5:0]  Block_col,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [5:0]  buf_address_a,
  output logic [5:0]  buf_address_b,
  input  logic [31:0] buf_read_data_a,
  input  logic [31:0] buf_read_data_b,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  bw_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [17:0] row_addr_q, row_addr_d;
  logic [17:0] stride_q, stride_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        we_n_q, we_n_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_data_q, sram_data_d;
  logic [5:0]  buf_a_q, buf_a_d;
  logic [5:0]  buf_b_q, buf_b_d;

  logic [17:0] w_base, w_stride, w_origin;
  logic [5:0]  w_col_limit;
  logic        w_legal;
  logic [1:0]  w_wr_w;
  logic [7:0]  w_pix_a, w_pix_b;

  clip_u8 u_clip_a (.i_sample(buf_read_data_a), .o_pixel(w_pix_a));
  clip_u8 u_clip_b (.i_sample(buf_read_data_b), .o_pixel(w_pix_b));

  always_comb begin
    w_base      = V_BASE;
    w_stride    = Y_STRIDE >> 1;
    w_col_limit = C_UV_BLOCK_COLS;
    case (Plane)
      PLANE_Y: begin
        w_base      = Y_BASE;
        w_stride    = Y_STRIDE;
        w_col_limit = C_Y_BLOCK_COLS;
      end
      PLANE_U: w_base = U_BASE;
      default: w_base = V_BASE;
    endcase
    w_legal  = (Plane != 2'd3) && (Block_row < C_BLOCK_ROWS) && (Block_col < w_col_limit);
    w_origin = w_base + (shift_add_mul(w_stride, {1'b0, Block_row}) << 3)
             + {10'd0, Block_col, 2'b00};
  end

  // Word captured this cycle lags the cycle counter by two (address + RAM latency).
  assign w_wr_w = cnt_q[1:0] - 2'd2;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_addr_d  = row_addr_q;
    stride_d    = stride_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    we_n_d      = 1'b1;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (w_legal) begin
            state_d    = ST_LEAD_IN;
            busy_d     = 1'b1;
            cnt_d      = 6'd1;
            buf_a_d    = 6'd0;
            buf_b_d    = 6'd1;
            row_addr_d = w_origin;
            stride_d   = w_stride;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_LEAD_IN: begin
        state_d = ST_WRITE;
        cnt_d   = cnt_q + 6'd1;
        buf_a_d = {cnt_q[4:0], 1'b0};
        buf_b_d = {cnt_q[4:0], 1'b1};
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q <= 6'd31) begin
          buf_a_d = {cnt_q[4:0], 1'b0};
          buf_b_d = {cnt_q[4:0], 1'b1};
        end
        if (cnt_q <= 6'd33) begin
          we_n_d      = 1'b0;
          sram_addr_d = row_addr_q + {16'd0, w_wr_w};
          sram_data_d = {w_pix_a, w_pix_b};
          if (w_wr_w == 2'd3) row_addr_d = row_addr_q + stride_q;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_addr_q  <= '0;
      stride_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      we_n_q      <= 1'b1;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      buf_a_q     <= '0;
      buf_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_addr_q  <= row_addr_d;
      stride_q    <= stride_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      we_n_q      <= we_n_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
    end
  end

  assign Busy            = busy_q;
  assign Done            = done_q;
  assign Error           = error_q;
  assign buf_address_a   = buf_a_q;
  assign buf_address_b   = buf_b_q;
  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = sram_data_q;
  assign SRAM_we_n       = we_n_q;

endmodule

`default_nettype wire
